// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake on both sides.
// S1 holds the operands and S2 holds the registered result, flags and a sticky overflow bit.
module alu_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   input  logic             clr_sticky,
   output logic             sticky_ovf
);

   localparam int unsigned Msb = WIDTH - 1;

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpShl  = 3'b101;
   localparam logic [2:0] OpShr  = 3'b110;
   localparam logic [2:0] OpRotl = 3'b111;

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [2:0]       s1_op_q;

   logic             s2_valid_q;
   logic [WIDTH-1:0] res_q;
   logic             ovf_q;
   logic             carry_q;
   logic             zero_q;
   logic             neg_q;
   logic             sticky_q;

   logic             s1_adv;
   logic             s2_adv;

   logic [SHW-1:0]     amt;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     dif_ext;
   logic [2*WIDTH-1:0] shl_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               alu_z;
   logic               alu_n;

   // in_ready is the only combinational input-to-output path (from out_ready).
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      amt     = s1_b_q[SHW-1:0];
      sum_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      dif_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      // Double-width shift so the bits pushed out of the top can be inspected.
      shl_ext = {{WIDTH{1'b0}}, s1_a_q} << amt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (s1_op_q)
         OpAdd: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (s1_a_q[Msb] == s1_b_q[Msb]) && (sum_ext[Msb] != s1_a_q[Msb]);
         end
         OpSub: begin
            alu_res = dif_ext[WIDTH-1:0];
            alu_c   = dif_ext[WIDTH];
            alu_v   = (s1_a_q[Msb] != s1_b_q[Msb]) && (dif_ext[Msb] != s1_a_q[Msb]);
         end
         OpAnd: alu_res = s1_a_q & s1_b_q;
         OpOr:  alu_res = s1_a_q | s1_b_q;
         OpXor: alu_res = s1_a_q ^ s1_b_q;
         OpShl: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_v   = |shl_ext[2*WIDTH-1:WIDTH];
         end
         OpShr:  alu_res = s1_a_q >> amt;
         // A right shift by WIDTH yields zero, so amount 0 rotates to a itself.
         OpRotl: alu_res = (s1_a_q << amt) | (s1_a_q >> (WIDTH - 32'(amt)));
         default: ;
      endcase
      alu_z = (alu_res == '0);
      alu_n = alu_res[Msb];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_op_q <= op;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q   <= alu_res;
            ovf_q   <= alu_v;
            carry_q <= alu_c;
            zero_q  <= alu_z;
            neg_q   <= alu_n;
         end
      end
   end

   // Set takes priority over clear when both happen on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (s2_valid_q && out_ready && ovf_q) begin
         sticky_q <= 1'b1;
      end else if (clr_sticky) begin
         sticky_q <= 1'b0;
      end
   end

   assign out_valid  = s2_valid_q;
   assign result     = res_q;
   assign overflow   = ovf_q;
   assign carry      = carry_q;
   assign zero       = zero_q;
   assign negative   = neg_q;
   assign sticky_ovf = sticky_q;

endmodule
